// File: rtl/uart_rx.sv
// uart_rx: UART receiver, 8N1 by default, 8E1 when UART_RX_PARITY_EN is defined.
// Two-flop input synchronizer, baud-table bit timing, one-cycle status strobes.
module uart_rx (
   input  logic       clock,
   input  logic       reset,
   input  logic [2:0] baud_rate_select,
   input  logic       Rx_Serial,
   output logic [7:0] Rx_Byte,
   output logic       Rx_Done,
   output logic       Rx_Active,
   output logic       Framing_Error,
   output logic       Parity_Error
);
   localparam int unsigned CNT_W  = 11;
   localparam int unsigned IDX_W  = 3;
   localparam int unsigned BYTE_W = 8;

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
   } state_t;

   state_t              state_q, state_d;
   logic                sync1_q, sync2_q;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [CNT_W-1:0]    n_q, n_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [BYTE_W-1:0]   shift_q, shift_d;
   logic [BYTE_W-1:0]   byte_q, byte_d;
   logic                done_q, done_d;
   logic                ferr_q, ferr_d;
   logic                perr_q, perr_d;
   logic                active_q, active_d;
   logic                rx_s, bit_end, half_end, par_bad;
   logic [CNT_W-1:0]    half_m1;
`ifdef UART_RX_PARITY_EN
   logic                par_q, par_d;
`endif

   function automatic logic [CNT_W-1:0] baud_n(input logic [2:0] sel);
      case (sel)
         3'b000:  baud_n = CNT_W'(1042);
         3'b001:  baud_n = CNT_W'(695);
         3'b010:  baud_n = CNT_W'(521);
         3'b011:  baud_n = CNT_W'(261);
         3'b100:  baud_n = CNT_W'(174);
         3'b101:  baud_n = CNT_W'(87);
         3'b110:  baud_n = CNT_W'(79);
         default: baud_n = CNT_W'(39);
      endcase
   endfunction

   assign rx_s     = sync2_q;
   assign half_m1  = (n_q >> 1) - CNT_W'(1);
   assign half_end = (cnt_q == half_m1);
   assign bit_end  = (cnt_q == n_q - CNT_W'(1));

`ifdef UART_RX_PARITY_EN
   assign par_bad = ^{shift_q, par_q};
`else
   assign par_bad = 1'b0;
`endif

   // Next-state and next-output logic; strobes default low every cycle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      n_d     = n_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      byte_d  = byte_q;
      done_d  = 1'b0;
      ferr_d  = 1'b0;
      perr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_d   = par_q;
`endif
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            idx_d = '0;
            if (!rx_s) begin
               state_d = S_START;
               n_d     = baud_n(baud_rate_select);
            end
         end
         S_START: begin
            if (half_end) begin
               cnt_d   = '0;
               state_d = rx_s ? S_IDLE : S_DATA;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DATA: begin
            if (bit_end) begin
               cnt_d          = '0;
               shift_d[idx_q] = rx_s;
               if (idx_q == IDX_W'(7)) begin
                  idx_d = '0;
`ifdef UART_RX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (bit_end) begin
               cnt_d   = '0;
               par_d   = rx_s;
               state_d = S_STOP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
`endif
         S_STOP: begin
            if (bit_end) begin
               cnt_d = '0;
               // Framing error wins over parity; a low stop parks in BREAK.
               if (!rx_s) begin
                  ferr_d  = 1'b1;
                  state_d = S_BREAK;
               end else if (par_bad) begin
                  perr_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  byte_d  = shift_q;
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_BREAK: begin
            cnt_d = '0;
            if (rx_s) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      active_d = (state_d != S_IDLE) && (state_d != S_BREAK);
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         sync1_q  <= 1'b1;
         sync2_q  <= 1'b1;
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         n_q      <= CNT_W'(39);
         idx_q    <= '0;
         shift_q  <= '0;
         byte_q   <= '0;
         done_q   <= 1'b0;
         ferr_q   <= 1'b0;
         perr_q   <= 1'b0;
         active_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_q    <= 1'b0;
`endif
      end else begin
         sync1_q  <= Rx_Serial;
         sync2_q  <= sync1_q;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         n_q      <= n_d;
         idx_q    <= idx_d;
         shift_q  <= shift_d;
         byte_q   <= byte_d;
         done_q   <= done_d;
         ferr_q   <= ferr_d;
         perr_q   <= perr_d;
         active_q <= active_d;
`ifdef UART_RX_PARITY_EN
         par_q    <= par_d;
`endif
      end
   end

   assign Rx_Byte       = byte_q;
   assign Rx_Done       = done_q;
   assign Rx_Active     = active_q;
   assign Framing_Error = ferr_q;
   assign Parity_Error  = perr_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized frame stimulus with a scoreboard of expected strobes
// (kind, byte, edge) derived from the frame timing rules.
module tb_uart_rx;
   logic       clock = 1'b0;
   logic       reset;
   logic [2:0] baud_rate_select;
   logic       Rx_Serial;
   logic [7:0] Rx_Byte;
   logic       Rx_Done;
   logic       Rx_Active;
   logic       Framing_Error;
   logic       Parity_Error;

   uart_rx dut (
      .clock            (clock),
      .reset            (reset),
      .baud_rate_select (baud_rate_select),
      .Rx_Serial        (Rx_Serial),
      .Rx_Byte          (Rx_Byte),
      .Rx_Done          (Rx_Done),
      .Rx_Active        (Rx_Active),
      .Framing_Error    (Framing_Error),
      .Parity_Error     (Parity_Error)
   );

   always #5 clock = ~clock;

   int unsigned cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      int          kind;   // 0 done, 1 framing, 2 parity
      logic [7:0]  data;
      int unsigned at;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [7:0]  last_good;
   int unsigned e0_g, stop_g;
   int unsigned n_tab [8] = '{1042, 695, 521, 261, 174, 87, 79, 39};

   function automatic void check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Monitor: every strobe must match the oldest outstanding expectation.
   exp_t mon_e;
   int   mon_kind;
   always @(negedge clock) begin
      if (reset === 1'b1 && (Rx_Done || Framing_Error || Parity_Error)) begin
         check("strobe_exclusive", int'(Rx_Done) + int'(Framing_Error) + int'(Parity_Error), 1);
         check("strobe_expected", longint'(sb.size() > 0), 1);
         if (sb.size() > 0) begin
            mon_e    = sb.pop_front();
            mon_kind = Rx_Done ? 0 : (Framing_Error ? 1 : 2);
            check("strobe_kind", mon_kind, mon_e.kind);
            check("rx_byte", Rx_Byte, mon_e.data);
            check("strobe_cycle", cyc, mon_e.at);
         end
      end
   end

   task automatic wait_cyc(input int unsigned t);
      int guard = 0;
      do begin
         @(negedge clock);
         guard++;
      end while (cyc < t && guard < 200000);
      check("wait_reach", cyc, t);
   endtask

   // Called at a rising-edge time; returns at the rising edge ending the stop bit.
   task automatic send_frame(input logic [7:0] d, input logic [2:0] sel,
                             input bit stop_ok, input bit par_flip);
      int unsigned n = n_tab[sel];
      bit perr = 1'b0;
`ifdef UART_RX_PARITY_EN
      perr = par_flip;
`endif
      baud_rate_select = sel;
      #1 Rx_Serial = 1'b0;
      e0_g   = cyc + 1;
      stop_g = e0_g + 2 + n / 2 + 9 * n;
`ifdef UART_RX_PARITY_EN
      stop_g = stop_g + n;
`endif
      if (!stop_ok)  sb.push_back('{1, last_good, stop_g});
      else if (perr) sb.push_back('{2, last_good, stop_g});
      else begin
         sb.push_back('{0, d, stop_g});
         last_good = d;
      end
      repeat (n) @(posedge clock);
      for (int i = 0; i < 8; i++) begin
         #1 Rx_Serial = d[i];
         if (i == 0) baud_rate_select = 3'($urandom);
         repeat (n) @(posedge clock);
      end
`ifdef UART_RX_PARITY_EN
      #1 Rx_Serial = (^d) ^ par_flip;
      repeat (n) @(posedge clock);
`endif
      #1 Rx_Serial = stop_ok;
      repeat (n) @(posedge clock);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   logic [7:0] rd;
   bit         rstop, rpar;
   logic [2:0] rsel;
   int unsigned e0;

   initial begin
      reset = 1'b0;
      baud_rate_select = 3'b111;
      Rx_Serial = 1'b1;
      last_good = 8'h00;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("reset_byte", Rx_Byte, 0);
      check("reset_done", Rx_Done, 0);
      check("reset_active", Rx_Active, 0);
      check("reset_ferr", Framing_Error, 0);
      check("reset_perr", Parity_Error, 0);
      @(posedge clock);
      #1 reset = 1'b1;
      repeat (5) @(posedge clock);

      // A5 at N=39 with Rx_Active window checks
      fork
         send_frame(8'hA5, 3'b111, 1'b1, 1'b0);
         begin
            @(negedge clock);
            wait_cyc(e0_g + 1);   check("a5_active_pre", Rx_Active, 0);
            wait_cyc(e0_g + 2);   check("a5_active_start", Rx_Active, 1);
            wait_cyc(stop_g - 1); check("a5_active_late", Rx_Active, 1);
            wait_cyc(stop_g);     check("a5_active_end", Rx_Active, 0);
         end
      join

      // back-to-back 00 then FF at N=87
      send_frame(8'h00, 3'b101, 1'b1, 1'b0);
      send_frame(8'hFF, 3'b101, 1'b1, 1'b0);
      repeat (20) @(posedge clock);

      // 10-cycle glitch on idle line
      baud_rate_select = 3'b111;
      #1 Rx_Serial = 1'b0;
      e0 = cyc + 1;
      repeat (10) @(posedge clock);
      #1 Rx_Serial = 1'b1;
      wait_cyc(e0 + 2 + 19 - 1); check("glitch_active", Rx_Active, 1);
      wait_cyc(e0 + 2 + 19);     check("glitch_released", Rx_Active, 0);
      @(posedge clock);
      repeat (20) @(posedge clock);

      // 3C with low stop, line held low
      send_frame(8'h3C, 3'b111, 1'b0, 1'b0);
      repeat (1000) @(posedge clock);
      @(negedge clock);
      check("break_inactive", Rx_Active, 0);
      check("break_byte_kept", Rx_Byte, 8'hFF);
      @(posedge clock);
      #1 Rx_Serial = 1'b1;
      repeat (40) @(posedge clock);

      // reset in the middle of 5A data bits, then clean 81
      baud_rate_select = 3'b111;
      #1 Rx_Serial = 1'b0;
      repeat (39) @(posedge clock);
      rd = 8'h5A;
      for (int i = 0; i < 3; i++) begin
         #1 Rx_Serial = rd[i];
         repeat (39) @(posedge clock);
      end
      #1 reset = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("midreset_byte", Rx_Byte, 0);
      check("midreset_active", Rx_Active, 0);
      check("midreset_done", Rx_Done, 0);
      check("midreset_ferr", Framing_Error, 0);
      last_good = 8'h00;
      @(posedge clock);
      #1 begin reset = 1'b1; Rx_Serial = 1'b1; end
      repeat (10) @(posedge clock);
      @(negedge clock);
      check("postreset_idle", Rx_Active, 0);
      @(posedge clock);
      send_frame(8'h81, 3'b111, 1'b1, 1'b0);
      repeat (10) @(posedge clock);

`ifdef UART_RX_PARITY_EN
      send_frame(8'h07, 3'b111, 1'b1, 1'b1);
      send_frame(8'h07, 3'b111, 1'b1, 1'b0);
      repeat (10) @(posedge clock);
`endif

      // randomized frames, gaps, select changes and error injection
      for (int f = 0; f < 16; f++) begin
         rd    = 8'($urandom);
         rsel  = 3'($urandom_range(7, 5));
         rstop = ($urandom_range(7, 0) != 0);
         rpar  = ($urandom_range(7, 0) == 0);
         send_frame(rd, rsel, rstop, rpar);
         if (!rstop) begin
            repeat ($urandom_range(30, 0)) @(posedge clock);
            #1 Rx_Serial = 1'b1;
            repeat (n_tab[rsel]) @(posedge clock);
         end else begin
            repeat ($urandom_range(3, 0)) @(posedge clock);
         end
      end

      repeat (50) @(posedge clock);
      check("scoreboard_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
